// File: rtl/cix_pkg.sv
// Shared definitions for the custom-instruction execution unit: opcodes, FSM states and
// helpers that locate instruction fields.
package cix_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_XOR = 5'b00100;
  localparam logic [4:0] OP_FFT = 5'b10000;
  localparam logic [4:0] OP_ENC = 5'b10001;
  localparam logic [4:0] OP_DEC = 5'b10010;
  localparam logic [4:0] OP_KEY = 5'b10011;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StIter
  } state_e;

  // Instruction is {opcode, rd, rs1, rs2}; field index counts up from the LSB.
  localparam int unsigned FLD_RS2 = 0;
  localparam int unsigned FLD_RS1 = 1;
  localparam int unsigned FLD_RD  = 2;
  localparam int unsigned FLD_OPC = 3;

  function automatic int unsigned fld_lsb(input int unsigned reg_aw, input int unsigned fld);
    return reg_aw * fld;
  endfunction

endpackage

// File: rtl/cix_regfile.sv
// Register file: two combinational read ports, one synchronous write port, r0 hardwired to
// zero, asynchronous active-low clear.
module cix_regfile #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [REG_AW-1:0] rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  localparam int unsigned NREGS = 2 ** REG_AW;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we_i && (wa_i != '0)) begin
      mem_d[wa_i] = wd_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ra_data_o = (ra_addr_i == '0) ? '0 : mem_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == '0) ? '0 : mem_q[rb_addr_i];

endmodule

// File: rtl/cix_exec_unit.sv
// Custom-instruction execution unit: accepts one instruction at a time, runs ALU/custom ops
// in one cycle and ENC/DEC as iterative rounds, then writes back and pulses res_valid.
module cix_exec_unit
  import cix_pkg::*;
#(
  parameter int unsigned DATA_W  = 19,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned ROUNDS  = 4,
  parameter int unsigned INSTR_W = OPC_W + 3 * REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic               res_valid,
  output logic               res_err,
  output logic               busy
);

  localparam int unsigned CntW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ROUNDS - 1);
  localparam int unsigned Rs2Lsb  = fld_lsb(REG_AW, FLD_RS2);
  localparam int unsigned Rs1Lsb  = fld_lsb(REG_AW, FLD_RS1);
  localparam int unsigned RdLsb   = fld_lsb(REG_AW, FLD_RD);
  localparam int unsigned OpcLsb  = fld_lsb(REG_AW, FLD_OPC);

  state_e            state_q, state_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, x_q, x_d, key_q, key_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d, res_err_q, res_err_d;

  logic [DATA_W-1:0] rf_a, rf_b, wr_data, alu_res, enc_t, round_out;
  logic              wr_en, legal, is_iter;

  cix_regfile #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr_i(instr[Rs1Lsb +: REG_AW]),
    .ra_data_o(rf_a),
    .rb_addr_i(instr[Rs2Lsb +: REG_AW]),
    .rb_data_o(rf_b),
    .we_i     (wr_en),
    .wa_i     (rd_q),
    .wd_i     (wr_data)
  );

  always_comb begin
    alu_res = '0;
    legal   = 1'b1;
    is_iter = 1'b0;
    case (opc_q)
      OPC_W'(OP_ADD): alu_res = a_q + b_q;
      OPC_W'(OP_SUB): alu_res = a_q - b_q;
      OPC_W'(OP_AND): alu_res = a_q & b_q;
      OPC_W'(OP_OR):  alu_res = a_q | b_q;
      OPC_W'(OP_XOR): alu_res = a_q ^ b_q;
      OPC_W'(OP_FFT): alu_res = b_q + 1'b1;
      OPC_W'(OP_KEY): alu_res = a_q;
      OPC_W'(OP_ENC), OPC_W'(OP_DEC): is_iter = 1'b1;
      default:        legal = 1'b0;
    endcase
  end

  // ENC: rotl1(x ^ key); DEC: rotr1(x) ^ key, which undoes one ENC round exactly.
  assign enc_t     = x_q ^ key_q;
  assign round_out = (opc_q == OPC_W'(OP_DEC)) ? ({x_q[0], x_q[DATA_W-1:1]} ^ key_q)
                                               : {enc_t[DATA_W-2:0], enc_t[DATA_W-1]};

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    rd_d        = rd_q;
    a_d         = a_q;
    b_d         = b_q;
    x_d         = x_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    res_err_d   = res_err_q;
    wr_en       = 1'b0;
    wr_data     = alu_res;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          opc_d   = instr[OpcLsb +: OPC_W];
          rd_d    = instr[RdLsb +: REG_AW];
          a_d     = rf_a;
          b_d     = rf_b;
          state_d = StExec;
        end
      end
      StExec: begin
        if (!legal) begin
          res_data_d  = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end else if (is_iter) begin
          x_d     = b_q;
          cnt_d   = '0;
          state_d = StIter;
        end else begin
          wr_en       = 1'b1;
          res_data_d  = alu_res;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          if (opc_q == OPC_W'(OP_KEY)) key_d = a_q;
          state_d     = StIdle;
        end
      end
      StIter: begin
        x_d   = round_out;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          wr_en       = 1'b1;
          wr_data     = round_out;
          res_data_d  = round_out;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      opc_q       <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      x_q         <= x_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
    end
  end

  assign instr_ready = (state_q == StIdle);
  assign busy        = !instr_ready;
  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_cix_exec_unit.sv
// Self-checking bench for cix_exec_unit: expected results are queued when an instruction is
// driven and popped when res_valid is observed.
module tb_cix_exec_unit;

  localparam int W = 19;
  localparam logic [4:0] O_ADD = 5'b00000, O_SUB = 5'b00001, O_AND = 5'b00010;
  localparam logic [4:0] O_OR = 5'b00011, O_XOR = 5'b00100, O_FFT = 5'b10000;
  localparam logic [4:0] O_ENC = 5'b10001, O_DEC = 5'b10010, O_KEY = 5'b10011;

  typedef struct packed {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  typedef struct packed {
    logic [4:0]   opc;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [W-1:0] ed;
  } step_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [19:0]  instr = '0;
  logic         instr_valid = 1'b0;
  logic         instr_ready, res_valid, res_err, busy;
  logic [W-1:0] res_data;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  cix_exec_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_err    (res_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [W-1:0] enc_ref(input logic [W-1:0] x, input logic [W-1:0] k);
    logic [W-1:0] t;
    t = x;
    for (int i = 0; i < 4; i++) begin
      t = t ^ k;
      t = {t[W-2:0], t[W-1]};
    end
    return t;
  endfunction

  // Drive one instruction from a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [4:0] opc, input int rd, input int rs1, input int rs2,
                       input logic [W-1:0] ed, input logic ee);
    exp_t ex;
    ex.d = ed;
    ex.e = ee;
    sb_q.push_back(ex);
    instr       = {opc, 5'(rd), 5'(rs1), 5'(rs2)};
    instr_valid = 1'b1;
    for (int i = 0; i < 100 && !instr_ready; i++) @(negedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Wait (bounded) for res_valid; lat counts edges after the accepting edge.
  task automatic result(output logic [W-1:0] d, output logic e, output int lat,
                        output bit busy_ok, output exp_t ex);
    lat = 0;
    busy_ok = 1'b1;
    d = 'x;
    e = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (res_valid) begin
        d = res_data;
        e = res_err;
        break;
      end
      if (!busy || instr_ready) busy_ok = 1'b0;
    end
    if (sb_q.size() != 0) ex = sb_q.pop_front();
    else ex = 'x;
  endtask

  task automatic op(input logic [4:0] opc, input int rd, input int rs1, input int rs2,
                    input logic [W-1:0] ed, input logic ee, output logic [W-1:0] d,
                    output logic e, output int lat, output bit bok, output exp_t ex);
    issue(opc, rd, rs1, rs2, ed, ee);
    result(d, e, lat, bok, ex);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b0 || res_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags got valid=%b err=%b want 0 0", res_valid, res_err);
    end
    n_cmp++;
    if (res_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0", res_data);
    end
    n_cmp++;
    if (busy !== 1'b0 || instr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state got busy=%b ready=%b want 0 1", busy, instr_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    logic [W-1:0] d;
    logic e;
    int lat;
    bit bok;
    exp_t ex;
    step_t tab [10] = '{
      '{O_FFT, 5'd1,  5'd0, 5'd0, 19'h00001},
      '{O_FFT, 5'd2,  5'd0, 5'd1, 19'h00002},
      '{O_ADD, 5'd3,  5'd1, 5'd2, 19'h00003},
      '{O_ADD, 5'd4,  5'd3, 5'd0, 19'h00003},
      '{O_SUB, 5'd5,  5'd0, 5'd1, 19'h7FFFF},
      '{O_FFT, 5'd6,  5'd0, 5'd5, 19'h00000},
      '{O_AND, 5'd10, 5'd3, 5'd2, 19'h00002},
      '{O_OR,  5'd10, 5'd5, 5'd1, 19'h7FFFF},
      '{O_XOR, 5'd10, 5'd3, 5'd1, 19'h00002},
      '{O_ADD, 5'd10, 5'd5, 5'd5, 19'h7FFFE}
    };
    foreach (tab[i]) begin
      op(tab[i].opc, int'(tab[i].rd), int'(tab[i].rs1), int'(tab[i].rs2), tab[i].ed, 1'b0,
         d, e, lat, bok, ex);
      n_cmp++;
      if (d !== ex.d || e !== ex.e || lat != 1) begin
        n_bad++;
        $display("FAIL alu_step%0d got d=%h e=%b lat=%0d want d=%h e=%b lat=1",
                 i, d, e, lat, ex.d, ex.e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b0 || res_data !== 19'h7FFFE) begin
      n_bad++;
      $display("FAIL valid_pulse got valid=%b data=%h want 0 7fffe", res_valid, res_data);
    end
  endtask

  task automatic test_enc();
    logic [W-1:0] d;
    logic e;
    int lat;
    bit bok;
    exp_t ex;
    op(O_KEY, 0, 0, 0, 19'h0, 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d || e !== ex.e || lat != 1) begin
      n_bad++;
      $display("FAIL key_zero got d=%h lat=%0d want d=%h lat=1", d, lat, ex.d);
    end
    op(O_ENC, 7, 0, 1, 19'h00010, 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d || e !== ex.e || lat != 5 || !bok) begin
      n_bad++;
      $display("FAIL enc_key0 got d=%h e=%b lat=%0d busy_ok=%0d want d=%h e=0 lat=5 busy_ok=1",
               d, e, lat, bok, ex.d);
    end
    op(O_DEC, 8, 0, 7, 19'h00001, 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d || e !== ex.e || lat != 5 || !bok) begin
      n_bad++;
      $display("FAIL dec_key0 got d=%h lat=%0d busy_ok=%0d want d=%h lat=5 busy_ok=1",
               d, lat, bok, ex.d);
    end
  endtask

  // Builds val in register rd by doubling and incrementing, then checks the final value.
  task automatic load_reg(input int rd, input logic [W-1:0] val);
    logic [W-1:0] d, m;
    logic e;
    int lat;
    bit bok;
    exp_t ex;
    m = '0;
    op(O_AND, rd, 0, 0, m, 1'b0, d, e, lat, bok, ex);
    for (int i = W - 1; i >= 0; i--) begin
      m = m << 1;
      op(O_ADD, rd, rd, rd, m, 1'b0, d, e, lat, bok, ex);
      if (val[i]) begin
        m = m + 1'b1;
        op(O_FFT, rd, 0, rd, m, 1'b0, d, e, lat, bok, ex);
      end
    end
    n_cmp++;
    if (d !== val || e !== 1'b0) begin
      n_bad++;
      $display("FAIL load_r%0d got %h want %h", rd, d, val);
    end
  endtask

  task automatic test_key();
    logic [W-1:0] d;
    logic e;
    int lat;
    bit bok;
    exp_t ex;
    load_reg(9, 19'h2AAAA);
    load_reg(11, 19'h12345);
    op(O_KEY, 0, 9, 0, 19'h2AAAA, 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d || lat != 1) begin
      n_bad++;
      $display("FAIL key_load got d=%h lat=%0d want d=%h lat=1", d, lat, ex.d);
    end
    op(O_ENC, 12, 0, 11, enc_ref(19'h12345, 19'h2AAAA), 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d || lat != 5) begin
      n_bad++;
      $display("FAIL enc_key got d=%h lat=%0d want d=%h lat=5", d, lat, ex.d);
    end
    op(O_DEC, 13, 0, 12, 19'h12345, 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d || lat != 5) begin
      n_bad++;
      $display("FAIL dec_key got d=%h lat=%0d want d=%h lat=5", d, lat, ex.d);
    end
    op(O_ADD, 0, 9, 0, 19'h2AAAA, 1'b0, d, e, lat, bok, ex);
    op(O_ADD, 14, 0, 0, 19'h0, 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d) begin
      n_bad++;
      $display("FAIL r0_zero got %h want %h", d, ex.d);
    end
    op(O_ADD, 14, 13, 0, 19'h12345, 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d) begin
      n_bad++;
      $display("FAIL dec_writeback got %h want %h", d, ex.d);
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] d;
    logic e;
    int lat;
    bit bok;
    exp_t ex;
    op(5'b11111, 1, 3, 2, 19'h0, 1'b1, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d || e !== ex.e || lat != 1) begin
      n_bad++;
      $display("FAIL illegal_11111 got d=%h e=%b lat=%0d want d=0 e=1 lat=1", d, e, lat);
    end
    op(5'b00101, 2, 3, 3, 19'h0, 1'b1, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d || e !== ex.e) begin
      n_bad++;
      $display("FAIL illegal_00101 got d=%h e=%b want d=0 e=1", d, e);
    end
    op(O_ADD, 14, 1, 0, 19'h00001, 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d || e !== ex.e) begin
      n_bad++;
      $display("FAIL illegal_no_write_r1 got d=%h e=%b want d=%h e=0", d, e, ex.d);
    end
    op(O_ADD, 14, 2, 0, 19'h00002, 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d || e !== ex.e) begin
      n_bad++;
      $display("FAIL illegal_no_write_r2 got d=%h e=%b want d=%h e=0", d, e, ex.d);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    logic e;
    int lat;
    bit bok;
    exp_t ex;
    issue(O_ENC, 7, 0, 1, 19'h00010, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid got valid=%b busy=%b ready=%b want 0 0 1",
               res_valid, busy, instr_ready);
    end
    void'(sb_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet got valid=%b busy=%b want 0 0", res_valid, busy);
    end
    op(O_ADD, 15, 7, 0, 19'h0, 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d || e !== ex.e) begin
      n_bad++;
      $display("FAIL reset_mid_r7 got %h want %h", d, ex.d);
    end
    op(O_ADD, 15, 1, 0, 19'h0, 1'b0, d, e, lat, bok, ex);
    n_cmp++;
    if (d !== ex.d) begin
      n_bad++;
      $display("FAIL reset_mid_r1 got %h want %h", d, ex.d);
    end
  endtask

  task automatic test_back_to_back();
    step_t tab [7] = '{
      '{O_FFT, 5'd1, 5'd0, 5'd0, 19'd1},
      '{O_FFT, 5'd2, 5'd0, 5'd1, 19'd2},
      '{O_ADD, 5'd3, 5'd2, 5'd2, 19'd4},
      '{O_ADD, 5'd4, 5'd3, 5'd1, 19'd5},
      '{O_SUB, 5'd5, 5'd4, 5'd2, 19'd3},
      '{O_XOR, 5'd6, 5'd5, 5'd4, 19'd6},
      '{O_FFT, 5'd7, 5'd0, 5'd6, 19'd7}
    };
    int extra;
    fork
      begin : driver
        int gap;
        exp_t ex;
        instr_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
          ex.d = tab[k].ed;
          ex.e = 1'b0;
          sb_q.push_back(ex);
          instr = {tab[k].opc, tab[k].rd, tab[k].rs1, tab[k].rs2};
          gap = (k == 0) ? 2 : 1;
          for (int i = 0; i < 20 && !instr_ready; i++) begin
            @(negedge clk);
            gap++;
          end
          if (k > 0) begin
            n_cmp++;
            if (gap != 2) begin
              n_bad++;
              $display("FAIL b2b_gap%0d got %0d cycles want 2", k, gap);
            end
          end
          @(negedge clk);
        end
        instr_valid = 1'b0;
      end
      begin : monitor
        logic got;
        exp_t ex;
        for (int k = 0; k < 7; k++) begin
          got = 1'b0;
          for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) begin
              got = 1'b1;
              break;
            end
          end
          if (sb_q.size() != 0) ex = sb_q.pop_front();
          else ex = 'x;
          n_cmp++;
          if (!got || res_data !== ex.d || res_err !== ex.e) begin
            n_bad++;
            $display("FAIL b2b_res%0d got valid=%b d=%h e=%b want d=%h e=0",
                     k, got, res_data, res_err, ex.d);
          end
        end
      end
    join
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (res_valid) extra++;
    end
    n_cmp++;
    if (extra != 0 || sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_extra got extra=%0d pending=%0d want 0 0", extra, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_enc();
    test_key();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
